quadrature_counter: RTL and testbench
=====================================

# quadrature_counter

Decodes the two quadrature channels of one wheel encoder into a signed 32-bit position count. It sits directly upstream of the speed/tick stage, which samples `count` on its slow clock. The block provides input synchronisation, glitch filtering, x4 decoding, direction and step reporting, and a sticky illegal-transition flag.

## Interface
- `FILTER_LEN`, default 4: consecutive cycles a synchronised channel must hold a new level before it is accepted (legal range 1..255).
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enc_a`  in  1  raw encoder channel A, asynchronous to `clock`.
- `enc_b`  in  1  raw encoder channel B, asynchronous to `clock`.
- `invert`  in  1  1 = negate the count direction (mirrored motor mounting).
- `clear`  in  1  synchronous zeroing of `count`, one-cycle pulse or level.
- `error_clr`  in  1  clears the sticky `error` flag.
- `count`  out  32  signed position, two's complement.
- `dir`  out  1  direction of the last accepted step (1 = up).
- `step`  out  1  one-cycle pulse per accepted count change.
- `error`  out  1  sticky; set on an illegal transition (both channels change together).

## Operation
- **Synchroniser:** two flops per channel (`a_s1`→`a_s2`, same for B).
- **Filter (per channel):** a counter `fcnt` and an accepted level `filt`.
  - If `sync2 == filt`, then `fcnt <= 0`.
  - Else if `fcnt == FILTER_LEN-1`, then `filt <= sync2` and `fcnt <= 0`.
  - Else `fcnt++`.
  - Glitches shorter than `FILTER_LEN` cycles are discarded.
- **Priming state machine:**
  - States are PRIME and RUN. Reset enters PRIME with a counter set to 0.
  - In PRIME, `filt` loads `sync2` directly every cycle, `prev` loads `filt`, and no decoding occurs.
  - After `FILTER_LEN+3` cycles the block moves to RUN. It never leaves RUN except through `reset`.
  - Purpose: encoder inputs that are high at reset do not produce spurious counts.
- **Decoder (RUN):** `prev <= {filt_a, filt_b}` every cycle.
  - Forward sequence 00→01→11→10→00 gives `inc = +1`.
  - Reverse sequence gives `inc = -1`.
  - No change gives `inc = 0`.
  - Both bits changed: `inc = 0` and `error <= 1`.
  - `invert = 1` negates `inc`.
- **Count update:** `count <= count + inc`, with 32-bit two's-complement wrap.
  - 0x7FFFFFFF + 1 wraps to 0x80000000.
  - 0x80000000 − 1 wraps to 0x7FFFFFFF.
- **Step and direction:** when `inc != 0`, `step <= 1` and `dir <= (inc > 0)`. Otherwise `step <= 0` and `dir` holds its value.
- **Clear:** `clear` has priority over any step in the same cycle. `count <= 0`, `step <= 0`, `dir` is unchanged, and `prev` is still updated, so the edge is consumed and not replayed.
- **Error flag:**
  - `error_clr` clears `error`.
  - If an illegal transition and `error_clr` occur in the same cycle, set wins and `error = 1`.
  - An illegal transition does not change `count`.

## Timing
- **Reset values (all registers):** `count = 0`, `dir = 0`, `step = 0`, `error = 0`, `fcnt = 0`, `filt = 0`, `prev = 00`, state = PRIME.
- **Latency:** let edge k be the first rising edge that samples a new level on a channel, with the level then held stable.
  - `filt` updates at edge k+1+`FILTER_LEN`.
  - `count` and `step` update at edge k+2+`FILTER_LEN`.
  - With `FILTER_LEN = 4`: 6 edges.
- **Throughput:** at most one count per channel transition. Separate A and B transitions must be at least `FILTER_LEN` cycles apart to be resolved individually.
- **Same-cycle acceptance:** A and B transitions whose filters accept in the same cycle count as illegal (error).
- **`step`:** high for exactly one cycle per count change. It is never high during PRIME or in a `clear` cycle.
- **Reset mid-operation:** everything returns to reset values on the next edge. In-flight filter progress is discarded.
- **`count` timing domain:** registered in the `clock` domain. The downstream slow-clock sampler accepts at most one-cycle skew, and every bit of `count` changes on the same edge.

## Test plan
- **Reset priming:** hold `enc_a = enc_b = 1` through `reset` and 20 cycles after release → `count = 0`, `step` never asserted, `error = 0`.
- **Forward and reverse:** drive 8 forward Gray steps spaced 10 cycles apart with `FILTER_LEN = 4` → `count = 8`, 8 `step` pulses, `dir = 1`, each step 6 edges after sampling. Then drive 3 reverse steps → `count = 5`, `dir = 0`. Repeat with `invert = 1` → `count = -5`.
- **Glitch rejection:** a 3-cycle pulse on `enc_a` with `FILTER_LEN = 4` → `count` unchanged, no `step`. A 4-cycle pulse → `count` +1 then −1.
- **Illegal transition:** change A and B on the same cycle from 00 to 11 → `error = 1`, `count` unchanged. Assert `error_clr` alone → `error = 0`. Assert `error_clr` in the same cycle as a new illegal transition → `error` stays 1.
- **Wrap and clear:**
  - Force `count` to 0x7FFFFFFF via 0x7FFFFFFF forward steps (or a bench backdoor), then one forward step → `count` = 0x80000000.
  - `clear` coinciding with a step → `count = 0`, `step = 0`, and the next legal step yields exactly ±1.
- **Reset mid-stream:** assert `reset` for 1 cycle while a filter count is at 2 → all outputs return to reset values on the next edge, and re-priming completes after `FILTER_LEN+3` cycles.

Source files
------------

// File: rtl/quadrature_counter_if.sv
// Encoder-facing and position-facing signals of quadrature_counter.
// The master drives the encoder/control inputs; the slave (the counter) drives position status.
interface quadrature_counter_if;
    logic        enc_a;
    logic        enc_b;
    logic        invert;
    logic        clear;
    logic        error_clr;
    logic [31:0] count;
    logic        dir;
    logic        step;
    logic        error;

    modport master (
        output enc_a, enc_b, invert, clear, error_clr,
        input  count, dir, step, error
    );

    modport slave (
        input  enc_a, enc_b, invert, clear, error_clr,
        output count, dir, step, error
    );
endinterface

// File: rtl/quadrature_counter.sv
// Quadrature encoder front end: synchroniser, per-channel glitch filter, priming FSM,
// x4 decoder and signed 32-bit position counter with sticky illegal-transition flag.
module quadrature_counter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    quadrature_counter_if.slave  bus
);
    typedef enum logic {PRIME, RUN} state_t;

    localparam logic [7:0] FCNT_LAST  = 8'(FILTER_LEN - 1);
    localparam logic [8:0] PRIME_LAST = 9'(FILTER_LEN + 2);

    state_t      state_q, state_d;
    logic [8:0]  prime_cnt_q, prime_cnt_d;
    logic        priming;

    logic        a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [7:0]  fcnt_a_q, fcnt_a_d, fcnt_b_q, fcnt_b_d;
    logic        filt_a_q, filt_a_d, filt_b_q, filt_b_d;
    logic [1:0]  prev_q, cur;
    logic [31:0] count_q, count_d;
    logic        dir_q, dir_d, step_q, step_d, error_q, error_d;
    logic        fwd_move, rev_move, move, up, illegal;

    function automatic logic [1:0] gray_next(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_next = 2'b01;
            2'b01:   gray_next = 2'b11;
            2'b11:   gray_next = 2'b10;
            default: gray_next = 2'b00;
        endcase
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= PRIME;
            prime_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    // Next state: PRIME lasts FILTER_LEN+3 cycles, RUN is terminal
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        if (state_q == PRIME) begin
            prime_cnt_d = prime_cnt_q + 9'd1;
            if (prime_cnt_q == PRIME_LAST) state_d = RUN;
        end
    end

    // FSM outputs
    always_comb begin
        priming = (state_q == PRIME);
    end

    always_comb begin
        filt_a_d = filt_a_q;
        fcnt_a_d = fcnt_a_q;
        filt_b_d = filt_b_q;
        fcnt_b_d = fcnt_b_q;
        if (priming) begin
            filt_a_d = a_s2_q;
            fcnt_a_d = '0;
            filt_b_d = b_s2_q;
            fcnt_b_d = '0;
        end else begin
            if (a_s2_q == filt_a_q) begin
                fcnt_a_d = '0;
            end else if (fcnt_a_q == FCNT_LAST) begin
                filt_a_d = a_s2_q;
                fcnt_a_d = '0;
            end else begin
                fcnt_a_d = fcnt_a_q + 8'd1;
            end
            if (b_s2_q == filt_b_q) begin
                fcnt_b_d = '0;
            end else if (fcnt_b_q == FCNT_LAST) begin
                filt_b_d = b_s2_q;
                fcnt_b_d = '0;
            end else begin
                fcnt_b_d = fcnt_b_q + 8'd1;
            end
        end
    end

    // Decoder; clear suppresses the step but prev still advances so the edge is consumed
    always_comb begin
        cur      = {filt_a_q, filt_b_q};
        fwd_move = (cur == gray_next(prev_q));
        rev_move = (prev_q == gray_next(cur));
        illegal  = !priming && ((cur ^ prev_q) == 2'b11);
        move     = !priming && (fwd_move || rev_move);
        up       = fwd_move ^ bus.invert;
        count_d  = count_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        if (bus.clear) begin
            count_d = '0;
        end else if (move) begin
            count_d = up ? count_q + 32'd1 : count_q - 32'd1;
            step_d  = 1'b1;
            dir_d   = up;
        end
        error_d = illegal ? 1'b1 : (bus.error_clr ? 1'b0 : error_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_s1_q   <= 1'b0;
            a_s2_q   <= 1'b0;
            b_s1_q   <= 1'b0;
            b_s2_q   <= 1'b0;
            fcnt_a_q <= '0;
            fcnt_b_q <= '0;
            filt_a_q <= 1'b0;
            filt_b_q <= 1'b0;
            prev_q   <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            a_s1_q   <= bus.enc_a;
            a_s2_q   <= a_s1_q;
            b_s1_q   <= bus.enc_b;
            b_s2_q   <= b_s1_q;
            fcnt_a_q <= fcnt_a_d;
            fcnt_b_q <= fcnt_b_d;
            filt_a_q <= filt_a_d;
            filt_b_q <= filt_b_d;
            prev_q   <= cur;
            count_q  <= count_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            error_q  <= error_d;
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.step  = step_q;
    assign bus.error = error_q;
endmodule

// File: tb/tb_quadrature_counter.sv
// Scoreboard bench for quadrature_counter: stimulus pushes expected step responses,
// a negedge monitor pops and checks each step pulse (value, direction, arrival cycle).
module tb_quadrature_counter;
    localparam int unsigned FL  = 4;
    localparam int unsigned LAT = FL + 3;

    typedef struct {
        int unsigned cyc;
        logic [31:0] cnt;
        logic        dir;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned steps_seen = 0;
    exp_t        sb[$];
    logic [1:0]  cur_ab;
    logic [31:0] exp_cnt;
    logic        exp_dir;
    logic [31:0] saved;
    int unsigned c0;

    quadrature_counter_if bus ();

    quadrature_counter #(.FILTER_LEN(FL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every step pulse must match the head of the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (bus.step === 1'b1) begin
            steps_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_step", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("step_count", bus.count, e.cnt);
                chk("step_dir", {31'd0, bus.dir}, {31'd0, e.dir});
                chk("step_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic logic [1:0] fwd(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Model one filtered transition old->nw accepted at drive cycle c
    task automatic model(input logic [1:0] old, input logic [1:0] nw, input int unsigned c);
        exp_t e;
        logic up;
        if (nw == fwd(old) || old == fwd(nw)) begin
            up = (nw == fwd(old)) ^ bus.invert;
            exp_cnt = up ? exp_cnt + 32'd1 : exp_cnt - 32'd1;
            exp_dir = up;
            e.cyc = c + LAT;
            e.cnt = exp_cnt;
            e.dir = exp_dir;
            sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_ab(input logic [1:0] nw);
        model(cur_ab, nw, cyc);
        cur_ab = nw;
        {bus.enc_a, bus.enc_b} = nw;
        wait_cyc(10);
    endtask

    task automatic pulse_a(input int unsigned len);
        logic [1:0] hi;
        c0 = cyc;
        hi = cur_ab ^ 2'b10;
        if (len >= FL) begin
            model(cur_ab, hi, c0);
            model(hi, cur_ab, c0 + len);
        end
        bus.enc_a = hi[1];
        wait_cyc(len);
        bus.enc_a = cur_ab[1];
        wait_cyc(14);
    endtask

    initial begin
        bus.enc_a = 1'b1;
        bus.enc_b = 1'b1;
        bus.invert = 1'b0;
        bus.clear = 1'b0;
        bus.error_clr = 1'b0;
        cur_ab = 2'b11;
        exp_cnt = '0;
        exp_dir = 1'b0;
        wait_cyc(3);
        chk("reset_count", bus.count, 32'd0);
        chk("reset_flags", {29'd0, bus.dir, bus.step, bus.error}, 32'd0);
        reset = 1'b0;
        wait_cyc(20);
        chk("prime_count", bus.count, 32'd0);
        chk("prime_error", {31'd0, bus.error}, 32'd0);

        // Forward / reverse
        for (int i = 0; i < 8; i++) set_ab(fwd(cur_ab));
        chk("fwd8_count", bus.count, 32'd8);
        chk("fwd8_dir", {31'd0, bus.dir}, 32'd1);
        chk("fwd8_steps", steps_seen, 32'd8);
        for (int i = 0; i < 3; i++) set_ab(rev(cur_ab));
        chk("rev3_count", bus.count, 32'd5);
        chk("rev3_dir", {31'd0, bus.dir}, 32'd0);

        // Inverted direction
        bus.clear = 1'b1;
        wait_cyc(1);
        bus.clear = 1'b0;
        exp_cnt = '0;
        chk("clear_count", bus.count, 32'd0);
        bus.invert = 1'b1;
        for (int i = 0; i < 8; i++) set_ab(fwd(cur_ab));
        for (int i = 0; i < 3; i++) set_ab(rev(cur_ab));
        chk("inv_count", bus.count, 32'hFFFF_FFFB);
        chk("inv_dir", {31'd0, bus.dir}, 32'd1);
        bus.invert = 1'b0;

        // Glitch rejection
        saved = bus.count;
        pulse_a(3);
        chk("glitch3_count", bus.count, saved);
        pulse_a(4);
        chk("glitch4_count", bus.count, saved);

        // Illegal transitions
        set_ab(cur_ab ^ 2'b11);
        chk("illegal_error", {31'd0, bus.error}, 32'd1);
        chk("illegal_count", bus.count, saved);
        bus.error_clr = 1'b1;
        wait_cyc(1);
        bus.error_clr = 1'b0;
        chk("errclr_error", {31'd0, bus.error}, 32'd0);
        cur_ab = cur_ab ^ 2'b11;
        {bus.enc_a, bus.enc_b} = cur_ab;
        bus.error_clr = 1'b1;
        wait_cyc(LAT);
        bus.error_clr = 1'b0;
        wait_cyc(2);
        chk("set_wins_error", {31'd0, bus.error}, 32'd1);
        bus.error_clr = 1'b1;
        wait_cyc(1);
        bus.error_clr = 1'b0;
        wait_cyc(5);

        // Wrap via backdoor
        force dut.count_q = 32'h7FFF_FFFF;
        wait_cyc(1);
        release dut.count_q;
        exp_cnt = 32'h7FFF_FFFF;
        chk("backdoor_count", bus.count, 32'h7FFF_FFFF);
        set_ab(fwd(cur_ab));
        chk("wrap_up", bus.count, 32'h8000_0000);
        set_ab(rev(cur_ab));
        chk("wrap_down", bus.count, 32'h7FFF_FFFF);

        // Clear coinciding with a step
        cur_ab = fwd(cur_ab);
        {bus.enc_a, bus.enc_b} = cur_ab;
        wait_cyc(LAT - 1);
        bus.clear = 1'b1;
        wait_cyc(1);
        bus.clear = 1'b0;
        exp_cnt = '0;
        chk("clrstep_count", bus.count, 32'd0);
        chk("clrstep_step", {31'd0, bus.step}, 32'd0);
        wait_cyc(10);
        set_ab(fwd(cur_ab));
        chk("after_clear", bus.count, 32'd1);

        // Reset mid-stream while filter A is at 2
        bus.enc_a = ~cur_ab[1];
        cur_ab[1] = ~cur_ab[1];
        wait_cyc(4);
        chk("fcnt_at_2", {24'd0, dut.fcnt_a_q}, 32'd2);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        exp_cnt = '0;
        chk("midrst_count", bus.count, 32'd0);
        chk("midrst_flags", {29'd0, bus.dir, bus.step, bus.error}, 32'd0);
        wait_cyc(FL + 2);
        chk("reprime_pending", int'(dut.state_q), 32'd0);
        wait_cyc(1);
        chk("reprime_done", int'(dut.state_q), 32'd1);
        wait_cyc(10);
        set_ab(fwd(cur_ab));
        chk("post_reset_step", bus.count, 32'd1);

        wait_cyc(10);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
